// File: rtl/nh_conv_mac_pkg.sv
// nh_conv_mac_pkg: sizing and pixel packing shared with the NH controller.
// Element idx = r*NH_DIM+c lives at [idx*PIX_WIDTH +: PIX_WIDTH].
package nh_conv_mac_pkg;

  localparam int NH_DIM    = 3;
  localparam int PIX_WIDTH = 8;
  localparam int WT_WIDTH  = 8;
  localparam int ACC_WIDTH = 20;
  localparam int OUT_WIDTH = 16;
  localparam int NH_SHIFT  = 0;

  localparam int N      = NH_DIM * NH_DIM;
  localparam int T      = $clog2(N);
  localparam int LAT    = T + 2;
  localparam int ADDR_W = $clog2(N);
  localparam int PROD_W = PIX_WIDTH + WT_WIDTH + 1;
  localparam int NH_W   = PIX_WIDTH * N;

  typedef logic [PIX_WIDTH-1:0]        pix_t;
  typedef logic signed [WT_WIDTH-1:0]  wt_t;
  typedef logic signed [PROD_W-1:0]    prod_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam logic [0:0] NO_KERNEL = 1'b0;
  localparam logic [0:0] ARMED     = 1'b1;

  function automatic pix_t nh_pix(
    input logic [NH_W-1:0] nh,
    input int              idx
  );
    return nh[idx*PIX_WIDTH +: PIX_WIDTH];
  endfunction

endpackage

// File: rtl/nh_conv_mac_if.sv
// nh_conv_mac_if: neighbourhood stream, weight bus and result port.
// master drives stream/weights; slave is the MAC.
interface nh_conv_mac_if;
  import nh_conv_mac_pkg::*;

  logic                        dval;
  logic [NH_W-1:0]             current_nh;
  logic                        wt_we;
  logic [ADDR_W-1:0]           wt_addr;
  wt_t                         wt_data;
  logic                        wt_commit;
  logic                        kernel_ready;
  logic                        result_valid;
  logic signed [OUT_WIDTH-1:0] result;
  logic                        drop_err;

  modport master (
    output dval, current_nh,
    output wt_we, wt_addr, wt_data, wt_commit,
    input  kernel_ready, result_valid,
    input  result, drop_err
  );

  modport slave (
    input  dval, current_nh,
    input  wt_we, wt_addr, wt_data, wt_commit,
    output kernel_ready, result_valid,
    output result, drop_err
  );

endinterface

// File: rtl/nh_conv_mac_adder_tree.sv
// nh_adder_tree: registered binary reduction, one level per cycle.
// Slot N_IN of every level is a constant zero, so odd leftovers pass through.
module nh_adder_tree #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 17,
  parameter int ACC_W = 20,
  parameter int LVL   = $clog2(N_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N_IN*IN_W-1:0]    in_data,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_sum
);

  logic signed [ACC_W-1:0] src [0:LVL-1][0:N_IN];
  logic signed [ACC_W-1:0] rg  [1:LVL][0:N_IN];
  logic [LVL:1]            vld;

  function automatic int clampi(input int k);
    return (k > N_IN) ? N_IN : k;
  endfunction

  // level 0 is the sign-extended input, deeper levels read registers
  always_comb begin
    for (int l = 0; l < LVL; l++)
      for (int i = 0; i <= N_IN; i++)
        src[l][i] = '0;
    for (int i = 0; i < N_IN; i++)
      src[0][i] = ACC_W'($signed(in_data[i*IN_W +: IN_W]));
    for (int l = 1; l < LVL; l++)
      for (int i = 0; i <= N_IN; i++)
        src[l][i] = rg[l][i];
  end

  // pairwise sums per level plus the matching valid shift
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 1; l <= LVL; l++)
        for (int i = 0; i <= N_IN; i++)
          rg[l][i] <= '0;
      vld <= '0;
    end else begin
      for (int l = 1; l <= LVL; l++)
        for (int i = 0; i <= N_IN; i++)
          rg[l][i] <= src[l-1][clampi(2*i)]
                    + src[l-1][clampi(2*i+1)];
      vld[1] <= in_valid;
      for (int l = 2; l <= LVL; l++)
        vld[l] <= vld[l-1];
    end
  end

  assign out_sum   = rg[LVL][0];
  assign out_valid = vld[LVL];

endmodule

// File: rtl/nh_conv_mac.sv
// nh_conv_mac: neighbourhood x double-buffered kernel, tree, scale, saturate.
// Define NH_CONV_MAC_RELU_EN to clamp negative results to zero.
module nh_conv_mac
  import nh_conv_mac_pkg::*;
#(
  parameter int SHIFT = NH_SHIFT
) (
  input logic          clock,
  input logic          reset,
  nh_conv_mac_if.slave bus
);

  localparam acc_t SAT_HI = acc_t'((1 <<< (OUT_WIDTH-1)) - 1);
  localparam acc_t SAT_LO = ~SAT_HI;

  logic [0:0]          state;
  wt_t                 shadow [0:N-1];
  wt_t                 active [0:N-1];
  prod_t               prod   [0:N-1];
  logic [N*PROD_W-1:0] prod_q;
  logic                v1;
  logic                tree_v;
  acc_t                tree_sum;
  acc_t                scaled;
  acc_t                sat;

  assign bus.kernel_ready = (state == ARMED);

  // kernel FSM and both weight banks; commit copies pre-write shadow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= NO_KERNEL;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (bus.wt_commit) begin
        state <= ARMED;
        for (int i = 0; i < N; i++)
          active[i] <= shadow[i];
      end
      if (bus.wt_we && (int'(bus.wt_addr) < N))
        shadow[bus.wt_addr] <= bus.wt_data;
    end
  end

  // element products against the bank active this cycle
  always_comb begin
    for (int i = 0; i < N; i++)
      prod[i] = $signed({1'b0, nh_pix(bus.current_nh, i)})
              * active[i];
  end

  // stage 1 register; neighbourhoods without a kernel are dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q       <= '0;
      v1           <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        prod_q[i*PROD_W +: PROD_W] <= prod[i];
      v1 <= bus.dval & bus.kernel_ready;
      if (bus.dval && !bus.kernel_ready)
        bus.drop_err <= 1'b1;
    end
  end

  nh_adder_tree #(
    .N_IN  (N),
    .IN_W  (PROD_W),
    .ACC_W (ACC_WIDTH)
  ) u_tree (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (v1),
    .in_data   (prod_q),
    .out_valid (tree_v),
    .out_sum   (tree_sum)
  );

  // floor shift then clamp into the signed output range
  always_comb begin
    scaled = tree_sum >>> SHIFT;
    sat    = scaled;
    if (scaled > SAT_HI)
      sat = SAT_HI;
    else if (scaled < SAT_LO)
      sat = SAT_LO;
`ifdef NH_CONV_MAC_RELU_EN
    if (sat[ACC_WIDTH-1])
      sat = '0;
`else
    sat = sat;
`endif
  end

  // output stage; result holds between valid beats
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.result_valid <= 1'b0;
      bus.result       <= '0;
    end else begin
      bus.result_valid <= tree_v;
      if (tree_v)
        bus.result <= sat[OUT_WIDTH-1:0];
    end
  end

endmodule
